// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, PC sequencer states and fetch increment.
// Imported by the fetch-stage PC sequencer slice.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    RUN,
    REDIR_WAIT,
    HALTED
  } pcseq_state_t;

  localparam word_t PC_INCR = 32'd4;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bus between the PC sequencer, hazard unit, imem interface and PC register.
// PC_SEQ_PERF_EN adds the stall_cycles / redirect_count counter outputs.
interface pc_sequencer_if;
  import cpu_types_pkg::*;

  word_t PC;
  logic  ihit;
  logic  hazard_stall;
  logic  jmp_valid;
  word_t jmp_target;
  logic  br_valid;
  word_t br_target;
  logic  halt;
  word_t next_PC;
  logic  pc_stall;
  logic  iREN;
  logic  flush_if;
  logic  halted;
`ifdef PC_SEQ_PERF_EN
  word_t stall_cycles;
  word_t redirect_count;
`endif

  modport master (
    input  PC, ihit, hazard_stall,
    input  jmp_valid, jmp_target,
    input  br_valid, br_target, halt,
    output next_PC, pc_stall, iREN,
    output flush_if, halted
`ifdef PC_SEQ_PERF_EN
    , stall_cycles, redirect_count
`endif
  );

  modport slave (
    output PC, ihit, hazard_stall,
    output jmp_valid, jmp_target,
    output br_valid, br_target, halt,
    input  next_PC, pc_stall, iREN,
    input  flush_if, halted
`ifdef PC_SEQ_PERF_EN
    , stall_cycles, redirect_count
`endif
  );

endinterface

// File: rtl/pc_seq_perf.sv
// Fetch performance counters: non-halted stall cycles and accepted redirects.
// Only instantiated when PC_SEQ_PERF_EN is defined; both counters wrap.
module pc_seq_perf
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  stallInc,
  input  logic  redirInc,
  output word_t stall_cycles,
  output word_t redirect_count
);

  word_t stallCnt;
  word_t redirCnt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stallCnt <= '0;
      redirCnt <= '0;
    end else begin
      if (stallInc) stallCnt <= stallCnt + 32'd1;
      if (redirInc) redirCnt <= redirCnt + 32'd1;
    end
  end

  assign stall_cycles   = stallCnt;
  assign redirect_count = redirCnt;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: next-PC select, redirect hold and halt FSM.
// Optional PC_SEQ_PERF_EN adds the pc_seq_perf counter block.
module pc_sequencer
  import cpu_types_pkg::*;
#(
  parameter word_t RESET_PC = '0
) (
  input logic           CLK,
  input logic           nRST,
  pc_sequencer_if.master bus
);

  pcseq_state_t state, nextState;
  word_t        pendTarget, nextPend;
  word_t        seqPc, redirTarget;
  logic         redirReq, redirAcc;

  assign seqPc       = bus.PC + PC_INCR;
  assign redirReq    = bus.br_valid |
                       (bus.jmp_valid & ~bus.hazard_stall);
  assign redirTarget = bus.br_valid ? bus.br_target
                                    : bus.jmp_target;

  always_comb begin
    nextState    = state;
    nextPend     = pendTarget;
    redirAcc     = 1'b0;
    bus.next_PC  = seqPc;
    bus.pc_stall = 1'b0;
    bus.iREN     = 1'b1;
    bus.flush_if = 1'b0;
    unique case (state)
      RUN: begin
        if (redirReq) begin
          redirAcc     = 1'b1;
          bus.flush_if = 1'b1;
          if (bus.ihit) begin
            bus.next_PC = redirTarget;
          end else begin
            nextPend     = redirTarget;
            bus.pc_stall = 1'b1;
            nextState    = REDIR_WAIT;
          end
        end else if (bus.halt) begin
          bus.pc_stall = 1'b1;
          nextState    = HALTED;
        end else begin
          bus.pc_stall = ~(bus.ihit & ~bus.hazard_stall);
        end
      end
      REDIR_WAIT: begin
        // the in-flight fetch is wrong-path; only a newer branch matters
        bus.flush_if = 1'b1;
        if (bus.br_valid) begin
          nextPend = bus.br_target;
          redirAcc = 1'b1;
        end
        bus.next_PC = nextPend;
        if (bus.ihit) nextState = RUN;
        else bus.pc_stall = 1'b1;
      end
      HALTED: begin
        bus.iREN     = 1'b0;
        bus.pc_stall = 1'b1;
      end
      default: nextState = RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= RUN;
      pendTarget <= RESET_PC;
      bus.halted <= 1'b0;
    end else begin
      state      <= nextState;
      pendTarget <= nextPend;
      bus.halted <= (nextState == HALTED);
    end
  end

`ifdef PC_SEQ_PERF_EN
  pc_seq_perf uPerf (
    .CLK            (CLK),
    .nRST           (nRST),
    .stallInc       (bus.pc_stall & (state != HALTED)),
    .redirInc       (redirAcc),
    .stall_cycles   (bus.stall_cycles),
    .redirect_count (bus.redirect_count)
  );
`else
  logic unusedRedirAcc;
  assign unusedRedirAcc = redirAcc;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed plan items plus random traffic.
// Expected outputs come from a rule-level fetch model; a negedge monitor checks.
module tb_pc_sequencer;
  import cpu_types_pkg::*;

  localparam word_t RST_PC = 32'h0;
  localparam int M_RUN  = 0;
  localparam int M_WAIT = 1;
  localparam int M_HALT = 2;

  typedef struct {
    word_t npc;
    bit    chkPc;
    bit    stall;
    bit    iren;
    bit    flush;
    bit    halted;
    word_t sc;
    word_t rc;
  } exp_t;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  pc_sequencer_if bus ();

  pc_sequencer #(.RESET_PC(RST_PC)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  exp_t  q[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    mMode = M_RUN;
  word_t mPend = RST_PC;
  bit    mHalted = 1'b0;
  word_t mSc = '0;
  word_t mRc = '0;
  word_t pcReg = RST_PC;
  int    haltCnt = 0;

  task automatic chk(input string n, input word_t act,
                     input word_t req);
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h (t=%0t)",
               n, act, req, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      vectors++;
      chk("pc_stall", word_t'(bus.pc_stall), word_t'(e.stall));
      chk("iREN", word_t'(bus.iREN), word_t'(e.iren));
      chk("flush_if", word_t'(bus.flush_if), word_t'(e.flush));
      chk("halted", word_t'(bus.halted), word_t'(e.halted));
      if (e.chkPc) chk("next_PC", bus.next_PC, e.npc);
`ifdef PC_SEQ_PERF_EN
      chk("stall_cycles", bus.stall_cycles, e.sc);
      chk("redirect_count", bus.redirect_count, e.rc);
`endif
    end
  end

  task automatic cyc(input bit ih, input bit hz,
                     input bit jv, input word_t jt,
                     input bit bv, input word_t bt,
                     input bit hl, input bit rst);
    exp_t  e;
    int    nMode;
    word_t nPend;
    bit    racc;
    @(posedge CLK);
    #1;
    if (rst) begin
      nRST    = 1'b0;
      mMode   = M_RUN;
      mHalted = 1'b0;
      pcReg   = RST_PC;
      mSc     = '0;
      mRc     = '0;
    end else begin
      nRST = 1'b1;
    end
    bus.PC           = pcReg;
    bus.ihit         = ih;
    bus.hazard_stall = hz;
    bus.jmp_valid    = jv;
    bus.jmp_target   = jt;
    bus.br_valid     = bv;
    bus.br_target    = bt;
    bus.halt         = hl;
    e.npc    = pcReg + 32'd4;
    e.chkPc  = 1'b0;
    e.stall  = 1'b0;
    e.iren   = 1'b1;
    e.flush  = 1'b0;
    e.halted = mHalted;
    e.sc     = mSc;
    e.rc     = mRc;
    nMode = mMode;
    nPend = mPend;
    racc  = 1'b0;
    if (mMode == M_RUN) begin
      if (bv || (jv && !hz)) begin
        racc    = 1'b1;
        e.flush = 1'b1;
        if (ih) begin
          e.npc   = bv ? bt : jt;
          e.chkPc = 1'b1;
        end else begin
          e.stall = 1'b1;
          nPend   = bv ? bt : jt;
          nMode   = M_WAIT;
        end
      end else if (hl) begin
        e.stall = 1'b1;
        nMode   = M_HALT;
      end else begin
        e.stall = !(ih && !hz);
        e.chkPc = 1'b1;
      end
    end else if (mMode == M_WAIT) begin
      e.flush = 1'b1;
      if (bv) begin
        nPend = bt;
        racc  = 1'b1;
      end
      if (ih) begin
        e.npc   = nPend;
        e.chkPc = 1'b1;
        nMode   = M_RUN;
      end else begin
        e.stall = 1'b1;
      end
    end else begin
      e.iren  = 1'b0;
      e.stall = 1'b1;
    end
    q.push_back(e);
    if (rst) begin
      mMode = M_RUN;
      mPend = RST_PC;
    end else begin
      if (e.stall && mMode != M_HALT) mSc = mSc + 32'd1;
      if (racc) mRc = mRc + 32'd1;
      if (!e.stall) pcReg = e.npc;
      mMode   = nMode;
      mPend   = nPend;
      mHalted = (nMode == M_HALT);
    end
    haltCnt = (mMode == M_HALT) ? haltCnt + 1 : 0;
  endtask

  initial begin
    bus.PC = '0; bus.ihit = 0; bus.hazard_stall = 0;
    bus.jmp_valid = 0; bus.jmp_target = '0;
    bus.br_valid = 0; bus.br_target = '0; bus.halt = 0;
    cyc(1, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 1);
    // sequential fetch
    pcReg = 32'h100;
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    // three-cycle miss, then PC+4
    pcReg = 32'h200;
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    // branch during pending fetch
    cyc(0, 0, 0, 0, 1, 32'h400, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    // branch beats jump and hazard; jump alone waits on hazard
    cyc(1, 1, 1, 32'h900, 1, 32'h800, 0, 0);
    cyc(1, 1, 1, 32'h900, 0, 0, 0, 0);
    // counters: 3 miss cycles and 2 redirects from reset
    cyc(1, 0, 0, 0, 0, 0, 0, 1);
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 32'h500, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 32'h600, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
`ifdef PC_SEQ_PERF_EN
    @(negedge CLK);
    #1;
    force dut.uPerf.stallCnt = 32'hFFFF_FFFF;
    #1;
    release dut.uPerf.stallCnt;
    mSc = 32'hFFFF_FFFF;
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
`endif
    // halt, later branch ignored, reset recovers
    cyc(1, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 1, 32'hA00, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      bit r;
      r = (haltCnt > 4) || ($urandom_range(99) == 0);
      cyc($urandom_range(99) < 60, $urandom_range(99) < 30,
          $urandom_range(99) < 20, $urandom & 32'hFFFF_FFFC,
          $urandom_range(99) < 15, $urandom & 32'hFFFF_FFFC,
          $urandom_range(99) < 4, r);
    end
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    #1;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d queued, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
